// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and
// the D-cache; latches the winner's request for the whole downstream transaction.
module l1_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              buf_mem_read,
  output logic              buf_mem_write,
  output logic [ADDR_W-1:0] buf_mem_address,
  output logic [LINE_W-1:0] buf_mem_wdata,
  input  logic [LINE_W-1:0] buf_mem_rdata,
  input  logic              buf_mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } line_req_t;

  state_t    state;
  logic      last_grant;  // 0 = I, 1 = D
  logic      busy;        // downstream strobe on, from grant through resp
  line_req_t lat;

  logic req_i, req_d, grant_d, d_is_write;

  assign req_i      = i_mem_read;
  assign req_d      = d_mem_read | d_mem_write;
  // Read+write together from the D-cache is resolved as a writeback.
  assign d_is_write = d_mem_write;
  // D wins when alone, or on a tie when I was served last.
  assign grant_d    = req_d & (~req_i | ~last_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      busy       <= 1'b0;
      lat        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i | req_d) begin
            last_grant <= grant_d;
            busy       <= 1'b1;
            if (grant_d) begin
              lat.addr  <= d_mem_address;
              lat.wdata <= d_mem_wdata;
              lat.write <= d_is_write;
              state     <= SERVE_D;
            end else begin
              lat.addr  <= i_mem_address;
              lat.write <= 1'b0;
              state     <= SERVE_I;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (buf_mem_resp) begin
            busy  <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign buf_mem_read    = busy & ~lat.write;
  assign buf_mem_write   = busy &  lat.write;
  assign buf_mem_address = lat.addr;
  assign buf_mem_wdata   = lat.wdata;

  // Data fans out unconditionally; only the handshake is steered to the owner.
  assign i_mem_rdata = buf_mem_rdata;
  assign d_mem_rdata = buf_mem_rdata;
  assign i_mem_resp  = (state == SERVE_I) & buf_mem_resp;
  assign d_mem_resp  = (state == SERVE_D) & buf_mem_resp;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized self-checking bench for l1_mem_arbiter against a transaction-level
// model of round-robin grants, latched requests and the response turnaround.
module tb_l1_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 0;
  logic          reset_n;
  logic          i_rd, d_rd, d_wr, b_resp;
  logic [AW-1:0] i_addr, d_addr, b_addr;
  logic [LW-1:0] d_wd, b_wd, b_rdata, i_rdata, d_rdata;
  logic          i_resp, d_resp, b_rd, b_wr;

  int errors = 0;
  int checks = 0;

  // model: who was served last (1 = D) and the last D line captured
  bit          m_last_d = 1;
  logic [LW-1:0] m_wd = '0;

  l1_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_mem_read(i_rd), .i_mem_address(i_addr), .i_mem_rdata(i_rdata), .i_mem_resp(i_resp),
    .d_mem_read(d_rd), .d_mem_write(d_wr), .d_mem_address(d_addr), .d_mem_wdata(d_wd),
    .d_mem_rdata(d_rdata), .d_mem_resp(d_resp),
    .buf_mem_read(b_rd), .buf_mem_write(b_wr), .buf_mem_address(b_addr),
    .buf_mem_wdata(b_wd), .buf_mem_rdata(b_rdata), .buf_mem_resp(b_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"}, LW'(b_rd), LW'(0));
    chk({tag, "_wr"}, LW'(b_wr), LW'(0));
    chk({tag, "_iresp"}, LW'(i_resp), LW'(0));
    chk({tag, "_dresp"}, LW'(d_resp), LW'(0));
  endtask

  function automatic logic [LW-1:0] rline();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic txn(input bit ri, input bit rdd, input bit wrd,
                     input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                     input logic [LW-1:0] wd, input int dly,
                     input logic [LW-1:0] rdat, output bit won_d);
    bit any_d, exp_wr;
    logic [AW-1:0] exp_a;
    any_d = rdd | wrd;
    i_rd = ri; d_rd = rdd; d_wr = wrd; i_addr = ai; d_addr = ad; d_wd = wd; b_resp = 0;
    won_d = 0;
    if (!ri && !any_d) begin
      @(posedge clk); @(negedge clk); #1;
      chk_quiet("noreq");
      return;
    end
    won_d    = (ri && any_d) ? !m_last_d : any_d;
    m_last_d = won_d;
    exp_wr   = won_d && wrd;
    exp_a    = won_d ? ad : ai;
    if (won_d) m_wd = wd;
    @(posedge clk); @(negedge clk);
    for (int j = 0; j <= dly; j++) begin
      #1;
      chk("strobe_rd", LW'(b_rd), LW'(!exp_wr));
      chk("strobe_wr", LW'(b_wr), LW'(exp_wr));
      chk("addr", LW'(b_addr), LW'(exp_a));
      chk("wdata", b_wd, m_wd);
      chk("early_resp", LW'({i_resp, d_resp}), LW'(0));
      // scramble inputs; the latched request must not move
      d_wd = rline(); i_addr = AW'($urandom); d_addr = AW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (won_d) begin d_rd = 0; d_wr = 0; end else i_rd = 0;
      end
      if (j < dly) @(negedge clk);
    end
    b_resp = 1; b_rdata = rdat; #1;
    chk("i_resp", LW'(i_resp), LW'(!won_d));
    chk("d_resp", LW'(d_resp), LW'(won_d));
    chk("i_rdata", i_rdata, rdat);
    chk("d_rdata", d_rdata, rdat);
    chk("resp_strobe", LW'(b_rd | b_wr), LW'(1));
    @(negedge clk);
    b_resp = 1'($urandom); #1;
    chk_quiet("release");
    @(negedge clk);
    b_resp = 1'($urandom); #1;
    chk_quiet("idle_gap");
    b_resp = 0;
  endtask

  initial begin
    bit won, pend_i, pend_d, ri, rdd, wrd;
    logic [AW-1:0] ai, ad;
    logic [LW-1:0] wd, tmp;
    reset_n = 0; i_rd = 1; i_addr = 16'h1230; d_rd = 0; d_wr = 0; d_addr = '0;
    d_wd = '0; b_resp = 0; b_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("rst");
    chk("rst_addr", LW'(b_addr), LW'(0));
    chk("rst_wdata", b_wd, '0);
    @(negedge clk); reset_n = 1;

    // first request out of reset: single I read, resp 3 cycles after the strobe
    tmp = {32'hDEAD0000, 64'h0, 32'h0000BEEF};
    txn(1, 0, 0, 16'h1230, 16'h0, '0, 3, tmp, won);
    chk("first_is_i", LW'(won), LW'(0));

    // D writeback with 0xA5 line
    txn(0, 0, 1, 16'h0, 16'h4440, {16{8'hA5}}, 2, rline(), won);

    // contention: both held for four transactions
    for (int k = 0; k < 4; k++) begin
      txn(1, 1, 0, 16'h1000 + 16'(k), 16'h2000 + 16'(k), rline(), k % 2, rline(), won);
      chk("alt_order", LW'(won), LW'(k % 2));
    end

    // read and write together from D behaves as a write
    txn(0, 1, 1, 16'h0, 16'h5550, rline(), 1, rline(), won);

    // stray response while idle
    b_resp = 1; #1;
    chk("stray_i", LW'(i_resp), LW'(0));
    chk("stray_d", LW'(d_resp), LW'(0));
    @(negedge clk); #1;
    chk_quiet("stray_after");
    b_resp = 0;

    // reset during SERVE_D
    d_wr = 1; d_addr = 16'h7770; d_wd = rline();
    @(posedge clk); @(negedge clk); #1;
    chk("pre_rst_wr", LW'(b_wr), LW'(1));
    #1 reset_n = 0; #1;
    chk("mid_rst_wr", LW'(b_wr), LW'(0));
    chk("mid_rst_rd", LW'(b_rd), LW'(0));
    b_resp = 1; #1;
    chk("mid_rst_dresp", LW'(d_resp), LW'(0));
    d_wr = 0; b_resp = 0; m_last_d = 1; m_wd = '0;
    @(negedge clk); reset_n = 1;
    @(negedge clk); #1;
    chk_quiet("post_rst");
    chk("post_rst_wdata", b_wd, '0);

    // randomized traffic; a losing requester keeps its request pending
    pend_i = 0; pend_d = 0; ai = '0; ad = '0; wd = '0; rdd = 0; wrd = 0;
    for (int n = 0; n < 60; n++) begin
      ri = pend_i | ($urandom_range(0, 2) == 0);
      if (!pend_i) ai = AW'($urandom);
      if (!pend_d) begin
        wrd = ($urandom_range(0, 3) == 0);
        rdd = ($urandom_range(0, 3) == 0);
        ad  = AW'($urandom);
        wd  = rline();
      end
      txn(ri, rdd, wrd, ai, ad, wd, $urandom_range(0, 3), rline(), won);
      pend_i = ri && won;
      pend_d = (rdd | wrd) && ri && !won;
      if (!pend_d) begin rdd = 0; wrd = 0; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected done");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
